store_buffer: RTL
=================

# store_buffer

In-order store buffer between execute/ROB commit and the data cache. Stores are allocated speculatively at execute, retired when the reorder buffer commits the matching ROB entry, and drained to the cache one per handshake. Younger loads get store-to-load forwarding or a stall on address conflict. ROB nuke discards uncommitted (speculative) stores.

## Interface
- SB_SIZE, 4, number of entries (power of two, 2..16)
- ROB_IDX_W, 4, width of ROB index tag
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_alloc  in  1  allocate store this cycle
- in_alloc_addr  in  32  store byte address
- in_alloc_data  in  32  store data, low bits significant
- in_alloc_size  in  2  00 byte, 01 half, 10 word
- in_alloc_rob_idx  in  ROB_IDX_W  ROB tag of store
- in_commit  in  1  ROB retired a store
- in_commit_rob_idx  in  ROB_IDX_W  tag of retired store
- in_nuke  in  1  ROB flush
- in_drain_ack  in  1  cache accepted head store
- in_load_valid  in  1  forwarding lookup request
- in_load_addr  in  32  load byte address
- in_load_size  in  2  load size, same encoding
- out_full  out  1  count == SB_SIZE
- out_empty  out  1  count == 0
- out_drain_valid  out  1  head entry committed
- out_drain_addr  out  32  word-aligned head address
- out_drain_data  out  32  lane-aligned head data
- out_drain_mask  out  4  head byte-enable mask
- out_fwd_hit  out  1  load fully covered by youngest overlapping store
- out_fwd_data  out  32  lane-aligned forwarded word
- out_load_stall  out  1  load overlaps buffered store, cannot forward

## Operation
- Circular FIFO: head, tail pointers (log2 SB_SIZE bits, wrap modulo SB_SIZE), count ($clog2(SB_SIZE+1) bits). Per entry: valid, committed, addr[31:2], data (lane-aligned), mask[3:0], rob_idx.
- Alloc: if in_alloc && !out_full && !in_nuke: write at tail, data shifted to lane addr[1:0], mask byte 0001<<a, half 0011<<a, word 1111; committed=0; tail++. Alloc when full is dropped (upstream must stall on out_full); alloc on the same cycle a pop frees space is still refused.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): not checked; ROB/execute raise exceptions beforehand.
- Commit: set committed on the valid, uncommitted entry whose rob_idx matches; no match ignored. Commits arrive in program order, so committed entries are contiguous from head.
- Drain: out_drain_valid = valid[head] && committed[head]. On in_drain_ack with out_drain_valid: clear head, head++. Ack without valid ignored.
- Nuke: all uncommitted entries invalidated; tail = head + committed count (mod SB_SIZE); count updated. Commit and drain ack in the nuke cycle are applied first, nuke second.
- Forwarding (combinational): scan from tail-1 toward head for youngest valid entry with equal addr[31:2] and nonzero mask overlap. No overlap: hit=0, stall=0. Overlap with entry mask covering load mask: hit=1, data = entry data. Partial overlap: stall=1. Outputs 0 when !in_load_valid.
- Committed entries forward identically to uncommitted ones.

## Timing
- Reset: all entries invalid, head=tail=count=0; out_full=0, out_empty=1, out_drain_valid=0, drain addr/data/mask=0, out_fwd_hit=0, out_fwd_data=0, out_load_stall=0. Reset mid-drain discards everything including committed stores.
- Alloc/commit/pop/nuke effects visible on outputs the cycle after the edge.
- Drain outputs are registered-state functions; hold stable until acked.
- Forwarding lookup: zero-cycle latency, combinational from current state (same-cycle allocate not visible).
- Throughput: one alloc, one commit, one pop per cycle concurrently.

## Configuration
- SB_FORWARD_EN defined: forwarding as above.
- Not defined: out_fwd_hit and out_fwd_data tied 0; any overlap, full or partial, asserts out_load_stall.

## Test plan
- Reset, alloc word 0x1000=0xDEADBEEF tag 3, commit tag 3 -> next cycle drain_valid=1, addr 0x1000, mask 1111; ack -> out_empty=1.
- Alloc byte 0x2003=0xAB, load byte 0x2003 -> fwd_hit=1, fwd_data=0xAB000000; load word 0x2000 -> load_stall=1.
- Fill SB_SIZE entries -> out_full=1; further alloc dropped, tail unchanged; commit+ack head -> full=0 next cycle.
- Alloc tags 1,2,3, commit 1, nuke -> count=1, only tag 1 drains; load to tag-2 address -> no hit, no stall.
- Alloc/ack across wrap (SB_SIZE+2 stores, each committed and drained) -> drain order equals alloc order.
- Build without SB_FORWARD_EN, repeat scenario 2 word-covering case -> fwd_hit=0, load_stall=1.

Source files
------------

// File: rtl/store_buffer_if.sv
// store_buffer_if: bus bundle between the core pipeline (master) and the store buffer (slave).
// Carries alloc/commit/nuke from execute and ROB, the cache drain handshake and the load lookup.
interface store_buffer_if #(
    parameter int unsigned ROB_IDX_W = 4
) ();
    logic                 in_alloc;
    logic [31:0]          in_alloc_addr;
    logic [31:0]          in_alloc_data;
    logic [1:0]           in_alloc_size;
    logic [ROB_IDX_W-1:0] in_alloc_rob_idx;
    logic                 in_commit;
    logic [ROB_IDX_W-1:0] in_commit_rob_idx;
    logic                 in_nuke;
    logic                 in_drain_ack;
    logic                 in_load_valid;
    logic [31:0]          in_load_addr;
    logic [1:0]           in_load_size;
    logic                 out_full;
    logic                 out_empty;
    logic                 out_drain_valid;
    logic [31:0]          out_drain_addr;
    logic [31:0]          out_drain_data;
    logic [3:0]           out_drain_mask;
    logic                 out_fwd_hit;
    logic [31:0]          out_fwd_data;
    logic                 out_load_stall;

    modport master (
        output in_alloc, in_alloc_addr, in_alloc_data, in_alloc_size, in_alloc_rob_idx,
        output in_commit, in_commit_rob_idx, in_nuke, in_drain_ack,
        output in_load_valid, in_load_addr, in_load_size,
        input  out_full, out_empty, out_drain_valid, out_drain_addr, out_drain_data,
        input  out_drain_mask, out_fwd_hit, out_fwd_data, out_load_stall
    );

    modport slave (
        input  in_alloc, in_alloc_addr, in_alloc_data, in_alloc_size, in_alloc_rob_idx,
        input  in_commit, in_commit_rob_idx, in_nuke, in_drain_ack,
        input  in_load_valid, in_load_addr, in_load_size,
        output out_full, out_empty, out_drain_valid, out_drain_addr, out_drain_data,
        output out_drain_mask, out_fwd_hit, out_fwd_data, out_load_stall
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order store buffer between execute/ROB commit and the data cache.
// Stores enter speculatively, become committed on ROB retire, and drain from the head.
// Optional feature macro SB_FORWARD_EN: when defined, fully covered loads are forwarded;
// when undefined, any overlap with a buffered store stalls the load.
module store_buffer #(
    parameter int unsigned SB_SIZE   = 4,
    parameter int unsigned ROB_IDX_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int unsigned PTR_W = (SB_SIZE > 1) ? $clog2(SB_SIZE) : 1;
    localparam int unsigned CNT_W = $clog2(SB_SIZE + 1);

    // Byte-enable mask for an access of the given size at the given lane offset.
    function automatic logic [3:0] f_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data moved into its byte lanes; bytes outside the access are zero.
    function automatic logic [31:0] f_lane_data(input logic [31:0] data, input logic [1:0] size,
                                                input logic [1:0] off);
        case (size)
            2'b00:   return 32'(data[7:0]) << {off, 3'b000};
            2'b01:   return 32'(data[15:0]) << {off, 3'b000};
            default: return data;
        endcase
    endfunction

    logic [SB_SIZE-1:0]   r_valid;
    logic [SB_SIZE-1:0]   r_comm;
    logic [29:0]          r_addr [SB_SIZE];
    logic [31:0]          r_data [SB_SIZE];
    logic [3:0]           r_mask [SB_SIZE];
    logic [ROB_IDX_W-1:0] r_rob  [SB_SIZE];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic [SB_SIZE-1:0]   w_valid_n;
    logic [SB_SIZE-1:0]   w_comm_n;
    logic [29:0]          w_addr_n [SB_SIZE];
    logic [31:0]          w_data_n [SB_SIZE];
    logic [3:0]           w_mask_n [SB_SIZE];
    logic [ROB_IDX_W-1:0] w_rob_n  [SB_SIZE];
    logic [PTR_W-1:0]     w_head_n;
    logic [PTR_W-1:0]     w_tail_n;
    logic [CNT_W-1:0]     w_count_n;

    logic                 w_full;
    logic                 w_drain_valid;
    logic                 w_pop;
    logic                 w_alloc;
    logic [3:0]           w_load_mask;
    logic                 w_fwd_match;
    logic [PTR_W-1:0]     w_fwd_idx;
    logic                 w_fwd_hit;
    logic [31:0]          w_fwd_data;
    logic                 w_load_stall;

    assign w_full        = (r_count == CNT_W'(SB_SIZE));
    assign w_drain_valid = r_valid[r_head] && r_comm[r_head];
    assign w_pop         = w_drain_valid && sb.in_drain_ack;
    // A slot freed by this cycle's pop is not reusable until next cycle.
    assign w_alloc       = sb.in_alloc && !w_full && !sb.in_nuke;

    // Next state: commit, then pop, then alloc, then nuke discards speculative entries.
    always_comb begin : p_next
        logic [PTR_W-1:0] v_idx;
        logic             v_found;
        logic [CNT_W-1:0] v_vcnt;
        logic [CNT_W-1:0] v_ccnt;
        w_valid_n = r_valid;
        w_comm_n  = r_comm;
        w_addr_n  = r_addr;
        w_data_n  = r_data;
        w_mask_n  = r_mask;
        w_rob_n   = r_rob;
        w_head_n  = r_head;
        w_tail_n  = r_tail;
        v_idx     = '0;
        v_found   = 1'b0;
        v_vcnt    = '0;
        v_ccnt    = '0;

        if (sb.in_commit) begin
            for (int unsigned k = 0; k < SB_SIZE; k++) begin
                v_idx = r_head + PTR_W'(k);
                if (!v_found && r_valid[v_idx] && !r_comm[v_idx] &&
                    (r_rob[v_idx] == sb.in_commit_rob_idx)) begin
                    w_comm_n[v_idx] = 1'b1;
                    v_found         = 1'b1;
                end
            end
        end

        if (w_pop) begin
            w_valid_n[r_head] = 1'b0;
            w_comm_n[r_head]  = 1'b0;
            w_head_n          = r_head + PTR_W'(1);
        end

        if (w_alloc) begin
            w_valid_n[r_tail] = 1'b1;
            w_comm_n[r_tail]  = 1'b0;
            w_addr_n[r_tail]  = sb.in_alloc_addr[31:2];
            w_data_n[r_tail]  = f_lane_data(sb.in_alloc_data, sb.in_alloc_size,
                                            sb.in_alloc_addr[1:0]);
            w_mask_n[r_tail]  = f_mask(sb.in_alloc_size, sb.in_alloc_addr[1:0]);
            w_rob_n[r_tail]   = sb.in_alloc_rob_idx;
            w_tail_n          = r_tail + PTR_W'(1);
        end

        if (sb.in_nuke) begin
            w_valid_n = w_valid_n & w_comm_n;
        end

        for (int i = 0; i < int'(SB_SIZE); i++) begin
            v_vcnt = v_vcnt + CNT_W'(w_valid_n[i]);
            v_ccnt = v_ccnt + CNT_W'(w_comm_n[i]);
        end

        // Committed entries are contiguous from head, so the survivors end at head + committed.
        if (sb.in_nuke) begin
            w_tail_n = w_head_n + PTR_W'(v_ccnt);
        end
        w_count_n = v_vcnt;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_comm  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(SB_SIZE); i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_mask[i] <= '0;
                r_rob[i]  <= '0;
            end
        end else begin
            r_valid <= w_valid_n;
            r_comm  <= w_comm_n;
            r_head  <= w_head_n;
            r_tail  <= w_tail_n;
            r_count <= w_count_n;
            r_addr  <= w_addr_n;
            r_data  <= w_data_n;
            r_mask  <= w_mask_n;
            r_rob   <= w_rob_n;
        end
    end

    // Load lookup: youngest valid entry in the same word with any byte overlap.
    always_comb begin : p_fwd
        logic [PTR_W-1:0] v_idx;
        logic             v_match;
        logic [PTR_W-1:0] v_sel;
        w_load_mask = f_mask(sb.in_load_size, sb.in_load_addr[1:0]);
        v_idx       = '0;
        v_match     = 1'b0;
        v_sel       = '0;
        for (int unsigned k = 0; k < SB_SIZE; k++) begin
            v_idx = r_tail - PTR_W'(k + 1);
            if (!v_match && r_valid[v_idx] && (r_addr[v_idx] == sb.in_load_addr[31:2]) &&
                ((r_mask[v_idx] & w_load_mask) != 4'b0000)) begin
                v_match = 1'b1;
                v_sel   = v_idx;
            end
        end
        w_fwd_match = v_match;
        w_fwd_idx   = v_sel;
    end

`ifdef SB_FORWARD_EN
    logic w_fwd_cover;
    assign w_fwd_cover  = ((r_mask[w_fwd_idx] & w_load_mask) == w_load_mask);
    assign w_fwd_hit    = sb.in_load_valid && w_fwd_match && w_fwd_cover;
    assign w_fwd_data   = w_fwd_hit ? r_data[w_fwd_idx] : 32'h0;
    assign w_load_stall = sb.in_load_valid && w_fwd_match && !w_fwd_cover;
`else
    logic [PTR_W-1:0] w_fwd_idx_unused;
    assign w_fwd_idx_unused = w_fwd_idx;
    assign w_fwd_hit        = 1'b0;
    assign w_fwd_data       = 32'h0;
    assign w_load_stall     = sb.in_load_valid && w_fwd_match;
`endif

    // Output drive; drain payload reads as zero while the head is not drainable.
    assign sb.out_full        = w_full;
    assign sb.out_empty       = (r_count == '0);
    assign sb.out_drain_valid = w_drain_valid;
    assign sb.out_drain_addr  = w_drain_valid ? {r_addr[r_head], 2'b00} : 32'h0;
    assign sb.out_drain_data  = w_drain_valid ? r_data[r_head] : 32'h0;
    assign sb.out_drain_mask  = w_drain_valid ? r_mask[r_head] : 4'h0;
    assign sb.out_fwd_hit     = w_fwd_hit;
    assign sb.out_fwd_data    = w_fwd_data;
    assign sb.out_load_stall  = w_load_stall;
endmodule
